us_timer_scheduler: RTL and testbench
=====================================

Name: us_timer_scheduler

Overview:
Multi-channel microsecond timer controller. It owns one shared 1 us prescaler and schedules NCH independent countdown channels on that common tick. Requesters start a timer with a req/ack handshake and receive a one-cycle done pulse on expiry. It sits between the 20 MHz system clock and control FSMs that need µs delays, replacing per-FSM prescalers.

Parameters:
NCH, 4, number of timer channels (1..8)
US_W, 16, width of per-channel duration in µs
CLK_PER_US, 20, clk cycles per µs (20 MHz); prescaler period exactly CLK_PER_US cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_req  in  NCH  per-channel start request, level, held until start_ack
start_us  in  NCH*US_W  per-channel duration; channel i uses bits [i*US_W +: US_W]; sampled on acceptance
start_ack  out  NCH  one-cycle acceptance pulse
cancel  in  NCH  abort running channel, one-cycle pulse
busy  out  NCH  channel running
done  out  NCH  one-cycle expiry pulse
tick_1us  out  1  prescaler tick, high one cycle per CLK_PER_US while any channel busy

Behaviour:
- One clock; reset synchronous, active-high. Reset takes priority over all inputs and clears all state. All outputs are 0 after reset, prescaler count = 0, and every channel is IDLE.
- All outputs are registered.
- Prescaler:
  - count runs 0..CLK_PER_US-1 and wraps.
  - tick_1us = 1 in the cycle count == CLK_PER_US-1.
  - The count is held at 0 while no channel is busy.
  - It starts from 0 in the first cycle any busy rises from all-idle.
  - It keeps free-running while any channel is busy. It is not restarted by later starts.
- Channel FSM per channel, states IDLE and RUN; remaining count rem is US_W bits.
  - IDLE: if start_req=1 and start_ack=0 this cycle, accept.
    - Next cycle start_ack=1.
    - If start_us != 0: rem <= start_us, state RUN, busy=1 (busy rises in the ack cycle).
    - If start_us == 0: stay IDLE, done=1 in the ack cycle.
  - RUN: on a tick cycle, rem decrements. When rem == 1 at the tick:
    - next cycle done=1, busy=0, state IDLE.
  - RUN with start_req=1: the request is ignored and stays pending, no ack. It is accepted once the channel is IDLE.
  - RUN with cancel=1: next cycle state IDLE, busy=0, no done pulse.
  - cancel in IDLE: no effect.
- Timing:
  - Start from all-idle: done fires exactly N*CLK_PER_US cycles after the ack cycle.
  - Start while others are running: done fires after N ticks, so the delay is in ((N-1)*CLK_PER_US, N*CLK_PER_US].
- Simultaneous events:
  - cancel and expiring tick in the same cycle: cancel wins, no done.
  - done cycle with start_req=1: the channel is IDLE, so it accepts, and ack follows the next cycle.
  - Different channels are fully independent. Multiple done/ack bits may be high in the same cycle.
- rem never wraps: decrement happens only when rem ≥ 1 and state RUN.
- Reset mid-run: all channels go IDLE with no done pulse. Requesters must re-request.

Optional Feature:
- Macro: US_TIMER_SCHED_RELOAD_EN.
- With the macro defined:
  - Adds input port periodic (NCH) and an internal reload register per channel, latched from start_us on acceptance.
  - If periodic[i]=1 at expiry, done pulses, rem reloads from the reload register, and the channel stays RUN (busy stays 1). Period is exactly N ticks.
  - cancel stops periodic mode.
  - start_us == 0 with periodic=1 is treated as one-shot.
- Without the macro: no periodic port, no reload registers, one-shot only.

Decomposition:
- Package us_timer_pkg holds:
  - channel state enum {CH_IDLE, CH_RUN}
  - default constants NCH_DEF=4, US_W_DEF=16, CLK_PER_US_DEF=20
  - prescaler width function clog2(CLK_PER_US)
- One sub-module, us_prescaler: enable-gated counter with tick output and restart-at-zero when disabled. Channels are a generate loop in the top.

Test Plan:
- Reset: assert rst 3 cycles mid-operation with a channel running -> all outputs 0 next cycle, no done; prescaler count 0.
- Single start: ch0 start_us=3 from all-idle, CLK_PER_US=20 -> ack 1 cycle after req; busy high from ack cycle; done exactly 60 cycles after ack; tick_1us seen 3 times.
- Zero duration: ch1 start_us=0 -> ack and done in the same cycle, busy never high.
- Concurrency: ch0 N=5 started; 7 cycles later ch2 N=1 -> ch2 done at ch0's next tick (13 cycles after its ack); ch0 done 100 cycles after its ack.
- Cancel race: ch3 N=2, pulse cancel in the expiring tick cycle -> no done, busy drops next cycle; pending start_req held during RUN is acked the cycle after IDLE.
- Reload (macro on): ch0 periodic=1, N=2 -> done every 40 cycles for 4 periods, busy stays 1; cancel -> busy 0, no further done.

Source files
------------

// File: rtl/us_timer_pkg.sv
// Shared types and defaults for the microsecond timer scheduler.
// Holds the per-channel state encoding, default parameter values and the
// prescaler counter width helper.
package us_timer_pkg;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_t;

   localparam int NCH_DEF        = 4;
   localparam int US_W_DEF       = 16;
   localparam int CLK_PER_US_DEF = 20;

   // Bits needed to count 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/us_prescaler.sv
// Purpose: shared 1 us prescaler; counts 0..CLK_PER_US-1 while enabled, sits at 0 when disabled.
// Latency: tick is registered and is high in the cycle the count equals CLK_PER_US-1.
// Backpressure: none; free-running while enabled, restarts from 0 after every idle period.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en       : any channel busy this cycle (advances the count)
//   en_nxt   : any channel busy next cycle (qualifies the registered tick)
//   tick     : one-cycle pulse per CLK_PER_US cycles while enabled
module us_prescaler
   import us_timer_pkg::*;
#(
   parameter int CLK_PER_US = CLK_PER_US_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic en_nxt,
   output logic tick
);

   localparam int                CNT_W = clog2(CLK_PER_US);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_PER_US - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             tick_q;
   logic             tick_d;

   always_comb begin
      count_d = '0;
      tick_d  = 1'b0;
      if (en) begin
         if (count_q == LAST) begin
            count_d = '0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
      // The tick is registered one cycle ahead, so it is qualified by the
      // next-cycle enable: no stray tick appears after the last channel stops.
      tick_d = en_nxt && (count_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/us_timer_scheduler.sv
// Purpose: NCH countdown timers in microseconds sharing one prescaler; start by req/ack, expiry by done pulse.
// Latency: start_ack one cycle after an accepted start_req; done N ticks after ack (exactly N*CLK_PER_US from all-idle).
// Backpressure: a start_req on a running channel is held pending (no ack) until the channel returns to idle.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset (clears everything, no done)
//   start_req  : per-channel level request, held until start_ack
//   start_us   : per-channel duration, channel i at [i*US_W +: US_W], sampled on acceptance
//   start_ack  : one-cycle acceptance pulse
//   cancel     : one-cycle abort of a running channel (no done)
//   periodic   : (US_TIMER_SCHED_RELOAD_EN only) reload and keep running at expiry
//   busy       : channel running
//   done       : one-cycle expiry pulse
//   tick_1us   : prescaler tick, only while some channel is busy
// Optional build macro: US_TIMER_SCHED_RELOAD_EN adds the periodic port and per-channel reload registers.
module us_timer_scheduler
   import us_timer_pkg::*;
#(
   parameter int NCH        = NCH_DEF,
   parameter int US_W       = US_W_DEF,
   parameter int CLK_PER_US = CLK_PER_US_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      start_req,
   input  logic [NCH*US_W-1:0] start_us,
   output logic [NCH-1:0]      start_ack,
   input  logic [NCH-1:0]      cancel,
`ifdef US_TIMER_SCHED_RELOAD_EN
   input  logic [NCH-1:0]      periodic,
`endif
   output logic [NCH-1:0]      busy,
   output logic [NCH-1:0]      done,
   output logic                tick_1us
);

   logic [NCH-1:0] run_nxt;
   logic           tick;

   // The prescaler counts on the current busy set and gates its registered
   // tick with the next-cycle busy set, so tick_1us never outlives the last
   // running channel.
   us_prescaler #(
      .CLK_PER_US (CLK_PER_US)
   ) u_presc (
      .clk    (clk),
      .rst    (rst),
      .en     (|busy),
      .en_nxt (|run_nxt),
      .tick   (tick)
   );

   assign tick_1us = tick;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ch_state_t        state_q;
      ch_state_t        state_d;
      logic [US_W-1:0]  rem_q;
      logic [US_W-1:0]  rem_d;
      logic             ack_q;
      logic             ack_d;
      logic             done_q;
      logic             done_d;
      logic [US_W-1:0]  req_us;
`ifdef US_TIMER_SCHED_RELOAD_EN
      logic [US_W-1:0]  reload_q;
      logic [US_W-1:0]  reload_d;
`endif

      assign req_us = start_us[i*US_W +: US_W];

      always_comb begin
         state_d = state_q;
         rem_d   = rem_q;
         ack_d   = 1'b0;
         done_d  = 1'b0;
`ifdef US_TIMER_SCHED_RELOAD_EN
         reload_d = reload_q;
`endif
         unique case (state_q)
            CH_IDLE: begin
               // ack_q blocks a second acceptance while the requester is
               // still dropping its level request in the ack cycle.
               if (start_req[i] && !ack_q) begin
                  ack_d = 1'b1;
                  if (req_us != '0) begin
                     rem_d   = req_us;
                     state_d = CH_RUN;
`ifdef US_TIMER_SCHED_RELOAD_EN
                     reload_d = req_us;
`endif
                  end else begin
                     // Zero duration expires immediately, alongside the ack.
                     done_d = 1'b1;
                  end
               end
            end
            CH_RUN: begin
               // Cancel beats an expiring tick in the same cycle.
               if (cancel[i]) begin
                  state_d = CH_IDLE;
                  rem_d   = '0;
               end else if (tick && (rem_q != '0)) begin
                  if (rem_q == US_W'(1)) begin
                     done_d = 1'b1;
`ifdef US_TIMER_SCHED_RELOAD_EN
                     if (periodic[i]) begin
                        rem_d = reload_q;
                     end else begin
                        state_d = CH_IDLE;
                        rem_d   = '0;
                     end
`else
                     state_d = CH_IDLE;
                     rem_d   = '0;
`endif
                  end else begin
                     rem_d = rem_q - US_W'(1);
                  end
               end
            end
            default: begin
               state_d = CH_IDLE;
               rem_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= CH_IDLE;
            rem_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef US_TIMER_SCHED_RELOAD_EN
            reload_q <= '0;
`endif
         end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
`ifdef US_TIMER_SCHED_RELOAD_EN
            reload_q <= reload_d;
`endif
         end
      end

      assign start_ack[i] = ack_q;
      assign done[i]      = done_q;
      assign busy[i]      = (state_q == CH_RUN);
      assign run_nxt[i]   = (state_d == CH_RUN);
   end

endmodule

// File: tb/tb_us_timer_scheduler.sv
// Bench for us_timer_scheduler: expected done cycles are queued when a start is
// driven and matched against done pulses by a negedge monitor.
module tb_us_timer_scheduler;

   localparam int NCH  = 4;
   localparam int US_W = 16;
   localparam int CPU  = 20;

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      start_req;
   logic [NCH*US_W-1:0] start_us;
   logic [NCH-1:0]      start_ack;
   logic [NCH-1:0]      cancel;
`ifdef US_TIMER_SCHED_RELOAD_EN
   logic [NCH-1:0]      periodic;
`endif
   logic [NCH-1:0]      busy;
   logic [NCH-1:0]      done;
   logic                tick_1us;

   us_timer_scheduler #(
      .NCH        (NCH),
      .US_W       (US_W),
      .CLK_PER_US (CPU)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start_req (start_req),
      .start_us  (start_us),
      .start_ack (start_ack),
      .cancel    (cancel),
`ifdef US_TIMER_SCHED_RELOAD_EN
      .periodic  (periodic),
`endif
      .busy      (busy),
      .done      (done),
      .tick_1us  (tick_1us)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int tick_cnt = 0;

   typedef struct {
      int ch;
      int cyc;
   } exp_t;
   exp_t exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %0d, required %0d (cycle %0d)", tag, act, expv, cyc);
      end
   endtask

   // Done monitor: every done pulse must match a queued expectation for its channel.
   always @(negedge clk) begin
      int idx;
      if (tick_1us === 1'b1) tick_cnt++;
      for (int i = 0; i < NCH; i++) begin
         if (done[i] === 1'b1) begin
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
               if (idx < 0 && exp_q[k].ch == i) idx = k;
            end
            if (idx < 0) begin
               check_eq($sformatf("spurious_done_ch%0d", i), done[i], 0);
            end else begin
               check_eq($sformatf("done_cycle_ch%0d", i), cyc, exp_q[idx].cyc);
               exp_q.delete(idx);
            end
         end
      end
   end

   // Start a channel at a negedge; queue done at (ack cycle + delay) when delay >= 0.
   task automatic start_ch(input int ch, input int n, input int delay, output int ack_cyc);
      int req_cyc;
      int w;
      start_us[ch*US_W +: US_W] = US_W'(n);
      start_req[ch] = 1'b1;
      req_cyc = cyc;
      if (delay >= 0) exp_q.push_back('{ch, req_cyc + 1 + delay});
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (start_ack[ch] !== 1'b1 && w < 50);
      check_eq($sformatf("ack_latency_ch%0d", ch), cyc - req_cyc, 1);
      start_req[ch] = 1'b0;
      ack_cyc = cyc;
      if (n != 0) check_eq($sformatf("busy_at_ack_ch%0d", ch), busy[ch], 1);
      else        check_eq($sformatf("busy_zero_dur_ch%0d", ch), busy[ch], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int a0;
      int b;
      rst       = 1'b1;
      start_req = '0;
      start_us  = '0;
      cancel    = '0;
`ifdef US_TIMER_SCHED_RELOAD_EN
      periodic  = '0;
`endif
      repeat (3) @(negedge clk);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_ack", start_ack, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_tick", tick_1us, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single start from all-idle: 3 us.
      tick_cnt = 0;
      start_ch(0, 3, 3 * CPU, a);
      repeat (3 * CPU - 1) @(negedge clk);
      check_eq("single_busy_before_done", busy[0], 1);
      check_eq("single_last_tick", tick_1us, 1);
      @(negedge clk);
      check_eq("single_busy_after_done", busy[0], 0);
      check_eq("single_tick_count", tick_cnt, 3);
      repeat (3) @(negedge clk);

      // Zero duration: ack and done together, never busy.
      start_ch(1, 0, 0, a);
      @(negedge clk);
      check_eq("zero_busy_after", busy[1], 0);
      repeat (3) @(negedge clk);

      // Concurrency: ch2 (1 us) started 7 cycles after ch0 (5 us) expires on ch0's next tick.
      start_ch(0, 5, 5 * CPU, a0);
      repeat (6) @(negedge clk);
      start_ch(2, 1, CPU - 7, b);
      check_eq("conc_ack_offset", b - a0, 7);
      repeat (5 * CPU - 7) @(negedge clk);
      check_eq("conc_all_idle", busy, 0);
      repeat (3) @(negedge clk);

      // Cancel in the expiring tick cycle; a start held during RUN is acked after IDLE.
      start_ch(3, 2, -1, a);
      repeat (10) @(negedge clk);
      start_us[3*US_W +: US_W] = US_W'(1);
      start_req[3] = 1'b1;
      repeat (2 * CPU - 11) @(negedge clk);
      check_eq("cancel_tick_cycle", tick_1us, 1);
      check_eq("pending_no_ack_run", start_ack[3], 0);
      cancel[3] = 1'b1;
      @(negedge clk);
      cancel[3] = 1'b0;
      check_eq("cancel_busy_drop", busy[3], 0);
      check_eq("pending_no_ack_idle", start_ack[3], 0);
      exp_q.push_back('{3, cyc + 1 + CPU});
      @(negedge clk);
      check_eq("pending_ack", start_ack[3], 1);
      start_req[3] = 1'b0;
      check_eq("pending_busy", busy[3], 1);
      repeat (CPU + 3) @(negedge clk);

      // Reset mid-run: no done, everything cleared, fresh start times exactly.
      start_ch(0, 5, -1, a);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_ack", start_ack, 0);
      check_eq("midrst_done", done, 0);
      check_eq("midrst_tick", tick_1us, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start_ch(1, 1, CPU, a);
      repeat (CPU + 3) @(negedge clk);
      check_eq("post_rst_idle", busy, 0);

`ifdef US_TIMER_SCHED_RELOAD_EN
      // Periodic reload: done every 2 us, busy stays high until cancel.
      periodic[0] = 1'b1;
      start_ch(0, 2, 2 * CPU, a);
      for (int k = 2; k <= 4; k++) exp_q.push_back('{0, a + k * 2 * CPU});
      repeat (2 * CPU) @(negedge clk);
      check_eq("reload_busy_first", busy[0], 1);
      repeat (6 * CPU) @(negedge clk);
      check_eq("reload_busy_fourth", busy[0], 1);
      repeat (5) @(negedge clk);
      cancel[0] = 1'b1;
      @(negedge clk);
      cancel[0] = 1'b0;
      periodic[0] = 1'b0;
      check_eq("reload_cancel_busy", busy[0], 0);
      repeat (5 * CPU) @(negedge clk);
      check_eq("reload_stays_idle", busy[0], 0);
`endif

      repeat (5) @(negedge clk);
      check_eq("pending_dones", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
